// File: rtl/i2c_mem_master.sv
// Bit-level serial master for memorycontroller: turns one request into a
// START / address / R/W / ACK / data / ACK / STOP frame and returns one response.
module i2c_mem_master #(
    parameter int ADDR_WIDTH  = 7,
    parameter int DATA_WIDTH  = 8,
    parameter int GAP_CYCLES  = 2,
    parameter int TAIL_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    input  logic                  req_write,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    output logic                  scl,
    output logic                  sda_out,
    output logic                  slv_reset_n,
    input  logic                  slv_ack_n,
    input  logic [DATA_WIDTH-1:0] slv_data_out
);

    localparam int MAX_W    = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CNT_W    = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam int MAX_WAIT = (GAP_CYCLES > TAIL_CYCLES) ? GAP_CYCLES : TAIL_CYCLES;
    localparam int WAIT_W   = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    localparam logic [CNT_W-1:0]  ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [WAIT_W-1:0] GAP_LAST  = WAIT_W'(GAP_CYCLES - 1);
    localparam logic [WAIT_W-1:0] TAIL_LAST = WAIT_W'(TAIL_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE,
        SRST,
        SETUP,
        START,
        ADDR,
        RW,
        ACK1,
        GAP,
        DATA,
        ACK2,
        STOP0,
        STOP1,
        TAIL,
        RESP
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  write_q;
    logic [CNT_W-1:0]      bit_cnt;
    logic [WAIT_W-1:0]     wait_cnt;

    // Outputs are assigned for the state being entered, so each bus value
    // appears in the cycle that state occupies. Address and data registers
    // shift right so the next bit to send is always at position 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            req_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            scl         <= 1'b1;
            sda_out     <= 1'b1;
            slv_reset_n <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            write_q     <= 1'b0;
            bit_cnt     <= '0;
            wait_cnt    <= '0;
        end else begin
            scl         <= 1'b1;
            sda_out     <= 1'b1;
            slv_reset_n <= 1'b1;
            req_ready   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        addr_q      <= req_addr;
                        data_q      <= req_data;
                        write_q     <= req_write;
                        rsp_data    <= '0;
                        rsp_err     <= 1'b0;
                        slv_reset_n <= 1'b0;
                        state       <= SRST;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                SRST: begin
                    state <= SETUP;
                end
                SETUP: begin
                    sda_out <= 1'b0;
                    state   <= START;
                end
                START: begin
                    sda_out <= addr_q[0];
                    addr_q  <= addr_q >> 1;
                    bit_cnt <= '0;
                    state   <= ADDR;
                end
                ADDR: begin
                    if (bit_cnt == ADDR_LAST) begin
                        sda_out <= write_q;
                        state   <= RW;
                    end else begin
                        sda_out <= addr_q[0];
                        addr_q  <= addr_q >> 1;
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                RW: begin
                    state <= ACK1;
                end
                ACK1: begin
                    if (slv_ack_n) begin
                        rsp_err <= 1'b1;
                        sda_out <= 1'b0;
                        state   <= STOP0;
                    end else if (write_q) begin
                        wait_cnt <= '0;
                        state    <= GAP;
                    end else begin
                        sda_out <= 1'b0;
                        state   <= STOP0;
                    end
                end
                GAP: begin
                    if (wait_cnt == GAP_LAST) begin
                        sda_out <= data_q[0];
                        data_q  <= data_q >> 1;
                        bit_cnt <= '0;
                        state   <= DATA;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_cnt == DATA_LAST) begin
                        state <= ACK2;
                    end else begin
                        sda_out <= data_q[0];
                        data_q  <= data_q >> 1;
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                ACK2: begin
                    if (slv_ack_n) begin
                        rsp_err <= 1'b1;
                    end
                    sda_out <= 1'b0;
                    state   <= STOP0;
                end
                STOP0: begin
                    state <= STOP1;
                end
                STOP1: begin
                    wait_cnt <= '0;
                    state    <= TAIL;
                end
                // Read data is only trusted once the slave has settled after STOP.
                TAIL: begin
                    if (wait_cnt == TAIL_LAST) begin
                        rsp_valid <= 1'b1;
                        if (!write_q && !rsp_err) begin
                            rsp_data <= slv_data_out;
                        end
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_mem_master.sv
// Self-checking bench for i2c_mem_master with a bus-decoding slave model and a
// request-level memory reference model.
module tb_i2c_mem_master;

    localparam int AW = 7;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_data = '0;
    logic          req_write = 1'b0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          scl;
    logic          sda_out;
    logic          slv_reset_n;
    logic          slv_ack_n = 1'b1;
    logic [DW-1:0] slv_data_out = '0;

    always #5 clk = ~clk;

    i2c_mem_master #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .GAP_CYCLES (2),
        .TAIL_CYCLES(2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_write   (req_write),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .scl         (scl),
        .sda_out     (sda_out),
        .slv_reset_n (slv_reset_n),
        .slv_ack_n   (slv_ack_n),
        .slv_data_out(slv_data_out)
    );

    int pass_count  = 0;
    int check_count = 0;

    // Reference memory updated from requests; slave memory updated from decoded bus bits.
    logic [DW-1:0] ref_mem   [0:127];
    logic [DW-1:0] slave_mem [0:127];

    logic    obs_sda  [0:63];
    logic    obs_rstn [0:63];
    int      rsp_cycle;
    int      accept_wait;
    logic [DW-1:0] got_data;
    logic    got_err;
    logic    timed_out;
    logic    hold_ok;
    logic    hs_rr;
    logic    post_rv;
    logic    post_rr;
    logic    scl_ok;

    // Expected sda_out in cycle T+k of a frame, built from the frame layout.
    function automatic logic exp_sda(input int k, input logic [AW-1:0] a,
                                     input logic [DW-1:0] d, input logic w, input logic n1);
        logic [AW-1:0] as;
        logic [DW-1:0] ds;
        if (k == 3) return 1'b0;
        if (k >= 4 && k < 4 + AW) begin
            as = a >> (k - 4);
            return as[0];
        end
        if (k == 4 + AW) return w;
        if (w && !n1) begin
            if (k >= 15 && k < 15 + DW) begin
                ds = d >> (k - 15);
                return ds[0];
            end
            if (k == 24) return 1'b0;
        end else if (k == 13) begin
            return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int exp_rsp_cycle(input logic w, input logic n1);
        return (w && !n1) ? 28 : 17;
    endfunction

    task automatic model_update(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                input logic w, input logic n1, input logic n2);
        if (w && !n1 && !n2) ref_mem[a] = d;
    endtask

    // Runs one request while acting as the slave; records what the DUT did.
    task automatic do_txn(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w,
                          input logic n1, input logic n2, input int hold);
        logic [AW-1:0] dec_a;
        logic [DW-1:0] dec_d;
        timed_out = 1'b0; rsp_cycle = -1; hold_ok = 1'b1; scl_ok = 1'b1; accept_wait = 0;
        hs_rr = 1'bx; post_rv = 1'bx; post_rr = 1'bx;
        dec_a = '0; dec_d = '0;
        for (int i = 0; i < 64; i++) begin
            obs_sda[i] = 1'bx;
            obs_rstn[i] = 1'bx;
        end
        req_addr = a; req_data = d; req_write = w; req_valid = 1'b1;
        while (req_ready !== 1'b1 && accept_wait < 40) begin
            @(negedge clk);
            accept_wait++;
        end
        if (req_ready !== 1'b1) begin
            timed_out = 1'b1;
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = AW'($urandom);
        req_data  = DW'($urandom);
        req_write = 1'($urandom_range(0, 1));
        for (int k = 1; k < 60; k++) begin
            obs_sda[k]  = sda_out;
            obs_rstn[k] = slv_reset_n;
            if (scl !== 1'b1) scl_ok = 1'b0;
            if (rsp_valid === 1'b1) begin
                rsp_cycle = k;
                got_data  = rsp_data;
                got_err   = rsp_err;
                break;
            end
            if (k == 11) begin
                for (int i = 0; i < AW; i++) dec_a = {obs_sda[4 + i], dec_a[AW-1:1]};
            end
            if (k == 23 && w && !n1) begin
                for (int i = 0; i < DW; i++) dec_d = {obs_sda[15 + i], dec_d[DW-1:1]};
                if (!n2) slave_mem[dec_a] = dec_d;
            end
            if (k == 12) slv_ack_n = n1;
            else if (k == 23 && w && !n1) slv_ack_n = n2;
            else slv_ack_n = 1'($urandom_range(0, 1));
            if (k == 16 && !w) slv_data_out = slave_mem[dec_a];
            else slv_data_out = DW'($urandom);
            @(negedge clk);
        end
        if (rsp_cycle < 0) begin
            timed_out = 1'b1;
            return;
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            slv_data_out = DW'($urandom);
            if (rsp_valid !== 1'b1 || rsp_data !== got_data || rsp_err !== got_err ||
                req_ready !== 1'b0) hold_ok = 1'b0;
        end
        hs_rr = req_ready;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        post_rv = rsp_valid;
        post_rr = req_ready;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_count++;
        if ({req_ready, rsp_valid, rsp_err, scl, sda_out, slv_reset_n} !== 6'b000110)
            $display("[TB] FAIL reset_outputs: got rdy/rv/err/scl/sda/rstn=%b required 000110",
                     {req_ready, rsp_valid, rsp_err, scl, sda_out, slv_reset_n});
        else pass_count++;
        check_count++;
        if (rsp_data !== 8'h00) $display("[TB] FAIL reset_rsp_data: got %h required 00", rsp_data);
        else pass_count++;
        reset = 1'b0;
        @(negedge clk);
        check_count++;
        if (req_ready !== 1'b1) $display("[TB] FAIL reset_release_ready: got %b required 1", req_ready);
        else pass_count++;
    endtask

    task automatic test_write_frame();
        logic [AW-1:0] a = 7'h64;
        logic [DW-1:0] d = 8'h1E;
        int bad = 0;
        do_txn(a, d, 1'b1, 1'b0, 1'b0, 0);
        check_count++;
        if (timed_out) $display("[TB] FAIL write_timeout: got no response, required one");
        else pass_count++;
        for (int k = 27; k >= 1; k--) if (obs_sda[k] !== exp_sda(k, a, d, 1'b1, 1'b0)) bad = k;
        check_count++;
        if (bad != 0) $display("[TB] FAIL write_sda: cycle T+%0d got %b required %b",
                               bad, obs_sda[bad], exp_sda(bad, a, d, 1'b1, 1'b0));
        else pass_count++;
        bad = 0;
        for (int k = 27; k >= 1; k--) if (obs_rstn[k] !== (k != 1)) bad = k;
        check_count++;
        if (bad != 0) $display("[TB] FAIL write_slv_reset_n: cycle T+%0d got %b required %b",
                               bad, obs_rstn[bad], bad != 1);
        else pass_count++;
        check_count++;
        if (rsp_cycle != 28) $display("[TB] FAIL write_rsp_cycle: got T+%0d required T+28", rsp_cycle);
        else pass_count++;
        check_count++;
        if ({got_err, got_data} !== 9'h000)
            $display("[TB] FAIL write_rsp: got err=%b data=%h required err=0 data=00", got_err, got_data);
        else pass_count++;
        check_count++;
        if (scl_ok !== 1'b1) $display("[TB] FAIL write_scl: got scl low, required 1");
        else pass_count++;
        model_update(a, d, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_read_frame();
        logic [AW-1:0] a = 7'h64;
        int bad = 0;
        logic [DW-1:0] exp_d;
        exp_d = ref_mem[a];
        do_txn(a, 8'h00, 1'b0, 1'b0, 1'b0, 0);
        for (int k = 16; k >= 1; k--) if (obs_sda[k] !== exp_sda(k, a, 8'h00, 1'b0, 1'b0)) bad = k;
        check_count++;
        if (bad != 0) $display("[TB] FAIL read_sda: cycle T+%0d got %b required %b",
                               bad, obs_sda[bad], exp_sda(bad, a, 8'h00, 1'b0, 1'b0));
        else pass_count++;
        check_count++;
        if (rsp_cycle != 17) $display("[TB] FAIL read_rsp_cycle: got T+%0d required T+17", rsp_cycle);
        else pass_count++;
        check_count++;
        if (got_data !== exp_d || got_err !== 1'b0)
            $display("[TB] FAIL read_rsp: got err=%b data=%h required err=0 data=%h", got_err, got_data, exp_d);
        else pass_count++;
    endtask

    task automatic test_nack();
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int bad = 0;
        a = AW'($urandom); d = DW'($urandom);
        do_txn(a, d, 1'b1, 1'b1, 1'b0, 0);
        for (int k = 16; k >= 1; k--) if (obs_sda[k] !== exp_sda(k, a, d, 1'b1, 1'b1)) bad = k;
        check_count++;
        if (bad != 0) $display("[TB] FAIL addr_nack_sda: cycle T+%0d got %b required %b",
                               bad, obs_sda[bad], exp_sda(bad, a, d, 1'b1, 1'b1));
        else pass_count++;
        check_count++;
        if (rsp_cycle != 17 || got_err !== 1'b1 || got_data !== 8'h00)
            $display("[TB] FAIL addr_nack_rsp: got T+%0d err=%b data=%h required T+17 err=1 data=00",
                     rsp_cycle, got_err, got_data);
        else pass_count++;
        a = AW'($urandom); d = DW'($urandom);
        do_txn(a, d, 1'b1, 1'b0, 1'b1, 0);
        bad = 0;
        for (int k = 27; k >= 1; k--) if (obs_sda[k] !== exp_sda(k, a, d, 1'b1, 1'b0)) bad = k;
        check_count++;
        if (bad != 0) $display("[TB] FAIL data_nack_sda: cycle T+%0d got %b required %b",
                               bad, obs_sda[bad], exp_sda(bad, a, d, 1'b1, 1'b0));
        else pass_count++;
        check_count++;
        if (rsp_cycle != 28 || got_err !== 1'b1 || got_data !== 8'h00)
            $display("[TB] FAIL data_nack_rsp: got T+%0d err=%b data=%h required T+28 err=1 data=00",
                     rsp_cycle, got_err, got_data);
        else pass_count++;
        do_txn(7'h64, 8'h00, 1'b0, 1'b1, 1'b0, 0);
        check_count++;
        if (rsp_cycle != 17 || got_err !== 1'b1 || got_data !== 8'h00)
            $display("[TB] FAIL read_nack_rsp: got T+%0d err=%b data=%h required T+17 err=1 data=00",
                     rsp_cycle, got_err, got_data);
        else pass_count++;
    endtask

    task automatic test_rsp_hold();
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        a = AW'($urandom); d = DW'($urandom);
        do_txn(a, d, 1'b1, 1'b0, 1'b0, 0);
        model_update(a, d, 1'b1, 1'b0, 1'b0);
        do_txn(a, 8'h00, 1'b0, 1'b0, 1'b0, 5);
        check_count++;
        if (hold_ok !== 1'b1) $display("[TB] FAIL hold_stable: got response change or req_ready=1, required stable");
        else pass_count++;
        check_count++;
        if (got_data !== ref_mem[a]) $display("[TB] FAIL hold_data: got %h required %h", got_data, ref_mem[a]);
        else pass_count++;
        check_count++;
        if (hs_rr !== 1'b0) $display("[TB] FAIL hold_handshake_ready: got %b required 0", hs_rr);
        else pass_count++;
        check_count++;
        if ({post_rv, post_rr} !== 2'b01)
            $display("[TB] FAIL hold_after_handshake: got rv/rdy=%b required 01", {post_rv, post_rr});
        else pass_count++;
    endtask

    task automatic test_reset_mid();
        int wait_n = 0;
        logic quiet = 1'b1;
        req_addr = 7'h2A; req_data = 8'h0F; req_write = 1'b1; req_valid = 1'b1;
        while (req_ready !== 1'b1 && wait_n < 40) begin
            @(negedge clk);
            wait_n++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 1; k < 18; k++) begin
            slv_ack_n = 1'b0;
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        check_count++;
        if ({scl, sda_out, slv_reset_n, rsp_valid, req_ready} !== 5'b11000)
            $display("[TB] FAIL midreset_outputs: got scl/sda/rstn/rv/rdy=%b required 11000",
                     {scl, sda_out, slv_reset_n, rsp_valid, req_ready});
        else pass_count++;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_count++;
        if (req_ready !== 1'b1) $display("[TB] FAIL midreset_ready: got %b required 1", req_ready);
        else pass_count++;
        for (int i = 0; i < 30; i++) begin
            if (rsp_valid !== 1'b0) quiet = 1'b0;
            @(negedge clk);
        end
        check_count++;
        if (quiet !== 1'b1) $display("[TB] FAIL midreset_no_rsp: got rsp_valid=1 required 0");
        else pass_count++;
        do_txn(7'h2A, 8'h5C, 1'b1, 1'b0, 1'b0, 1);
        model_update(7'h2A, 8'h5C, 1'b1, 1'b0, 1'b0);
        do_txn(7'h2A, 8'h00, 1'b0, 1'b0, 1'b0, 0);
        check_count++;
        if (got_data !== 8'h5C || got_err !== 1'b0)
            $display("[TB] FAIL midreset_recover: got err=%b data=%h required err=0 data=5c", got_err, got_data);
        else pass_count++;
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic w, n1, n2;
        logic [DW-1:0] exp_d;
        logic exp_e;
        for (int i = 0; i < 16; i++) begin
            a  = AW'($urandom_range(0, 7));
            d  = DW'($urandom);
            w  = 1'($urandom_range(0, 1));
            n1 = ($urandom_range(0, 3) == 0);
            n2 = ($urandom_range(0, 3) == 0);
            exp_e = n1 | (w & n2);
            exp_d = (w || n1) ? 8'h00 : ref_mem[a];
            do_txn(a, d, w, n1, n2, $urandom_range(0, 2));
            model_update(a, d, w, n1, n2);
            check_count++;
            if (i > 0 && accept_wait != 0) $display("[TB] FAIL b2b_accept: got %0d wait cycles required 0", accept_wait);
            else pass_count++;
            check_count++;
            if (rsp_cycle != exp_rsp_cycle(w, n1) || got_err !== exp_e || got_data !== exp_d)
                $display("[TB] FAIL b2b_rsp[%0d]: got T+%0d err=%b data=%h required T+%0d err=%b data=%h",
                         i, rsp_cycle, got_err, got_data, exp_rsp_cycle(w, n1), exp_e, exp_d);
            else pass_count++;
        end
    endtask

    task automatic test_sweep();
        logic [DW-1:0] d;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 128; i++) begin
                d = (pass == 0) ? DW'(i) : DW'($urandom);
                do_txn(AW'(i), d, 1'b1, 1'b0, 1'b0, 0);
                model_update(AW'(i), d, 1'b1, 1'b0, 1'b0);
                do_txn(AW'(i), 8'h00, 1'b0, 1'b0, 1'b0, 0);
                check_count++;
                if (got_data !== d || got_err !== 1'b0 || timed_out)
                    $display("[TB] FAIL sweep[%0d] addr %0d: got err=%b data=%h required err=0 data=%h",
                             pass, i, got_err, got_data, d);
                else pass_count++;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            ref_mem[i]   = '0;
            slave_mem[i] = '0;
        end
        test_reset();
        test_write_frame();
        test_read_frame();
        test_nack();
        test_rsp_hold();
        test_reset_mid();
        test_back_to_back();
        test_sweep();
        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
